// File: rtl/acc_tx_scheduler.sv
// acc_tx_scheduler
//   Buffers 16-bit accumulator words in a small FIFO and feeds them to the
//   UART byte transmitter as two bytes per word, with a start/done handshake.
//   Flags dropped words and counts fully transmitted words for the LEDs.
//
// Ports
//   CLK       system clock, rising edge
//   RESET     asynchronous reset, active low
//   DATA_IN   accumulator word to queue
//   WR        write strobe, one word per high cycle
//   TX_BUSY   transmitter busy; no start is issued while high
//   TX_DONE   one-cycle pulse, transmitter finished a byte
//   TX_START  one-cycle request to send TX_DATA (decoded from state)
//   TX_DATA   byte to send, registered
//   FULL      FIFO holds 2**DEPTH_LOG2 words (registered)
//   EMPTY     FIFO holds no words (registered)
//   OVERFLOW  sticky, a word was dropped because the FIFO was full
//   SENT_CNT  count of fully transmitted words, wraps 255 -> 0
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | nothing in flight, waiting for a queued word
// LOAD   | pop FIFO head into word register, present first byte
// SEND_A | request first byte once transmitter is free
// WAIT_A | first byte on the wire, wait for TX_DONE
// SEND_B | request second byte once transmitter is free
// WAIT_B | second byte on the wire, wait for TX_DONE

module acc_tx_scheduler #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 2,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              WR,
   input  logic              TX_BUSY,
   input  logic              TX_DONE,
   output logic              TX_START,
   output logic [7:0]        TX_DATA,
   output logic              FULL,
   output logic              EMPTY,
   output logic              OVERFLOW,
   output logic [7:0]        SENT_CNT
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SEND_A = 3'd2,
      ST_WAIT_A = 3'd3,
      ST_SEND_B = 3'd4,
      ST_WAIT_B = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_W-1:0]       mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    full_q, full_d;
   logic                    empty_q, empty_d;
   logic                    overflow_q, overflow_d;
   logic [DATA_W-1:0]       word_q, word_d;
   logic [7:0]              tx_data_q, tx_data_d;
   logic [7:0]              sent_cnt_q, sent_cnt_d;
   logic [DATA_W-1:0]       head;
   logic                    push;
   logic                    pop;
   logic                    tx_start;

   assign head = mem_q[rd_ptr_q];

   // FIFO bookkeeping. A write while full is dropped even if the FSM pops
   // in the same cycle: FULL is a registered flag and is the only gate.
   always_comb begin
      push       = WR & ~full_q;
      pop        = (state_q == ST_LOAD);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (WR & full_q);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == DEPTH_CNT);
      empty_d = (count_d == '0);
   end

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      tx_data_d  = tx_data_q;
      sent_cnt_d = sent_cnt_q;
      tx_start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty_q) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            word_d    = head;
            tx_data_d = MSB_FIRST ? head[15:8] : head[7:0];
            state_d   = ST_SEND_A;
         end
         ST_SEND_A: begin
            if (!TX_BUSY) begin
               tx_start = 1'b1;
               state_d  = ST_WAIT_A;
            end
         end
         ST_WAIT_A: begin
            if (TX_DONE) begin
               tx_data_d = MSB_FIRST ? word_q[7:0] : word_q[15:8];
               state_d   = ST_SEND_B;
            end
         end
         ST_SEND_B: begin
            if (!TX_BUSY) begin
               tx_start = 1'b1;
               state_d  = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            if (TX_DONE) begin
               sent_cnt_d = sent_cnt_q + 8'd1;
               state_d    = empty_q ? ST_IDLE : ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Storage is not reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= DATA_IN;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         word_q     <= '0;
         tx_data_q  <= 8'h00;
         sent_cnt_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         word_q     <= word_d;
         tx_data_q  <= tx_data_d;
         sent_cnt_q <= sent_cnt_d;
      end
   end

   assign TX_START = tx_start;
   assign TX_DATA  = tx_data_q;
   assign FULL     = full_q;
   assign EMPTY    = empty_q;
   assign OVERFLOW = overflow_q;
   assign SENT_CNT = sent_cnt_q;

endmodule

// File: tb/tb_acc_tx_scheduler.sv
module tb_acc_tx_scheduler;

   logic        clk_sys;
   logic        rst_b;
   logic [15:0] data_in;
   logic        wr;
   logic        tx_busy;
   logic        tx_done;

   logic        tx_start_m, tx_start_l;
   logic [7:0]  tx_data_m, tx_data_l;
   logic        full_m, full_l;
   logic        empty_m, empty_l;
   logic        ovf_m, ovf_l;
   logic [7:0]  sent_m, sent_l;

   int          n_total = 0;
   int          n_bad   = 0;

   logic [7:0]  bytes_m [$];
   logic [7:0]  bytes_l [$];
   int          done_dly;

   // high byte first
   acc_tx_scheduler #(.DATA_W(16), .DEPTH_LOG2(2), .MSB_FIRST(1'b1)) dut (
      .CLK(clk_sys), .RESET(rst_b), .DATA_IN(data_in), .WR(wr),
      .TX_BUSY(tx_busy), .TX_DONE(tx_done), .TX_START(tx_start_m),
      .TX_DATA(tx_data_m), .FULL(full_m), .EMPTY(empty_m),
      .OVERFLOW(ovf_m), .SENT_CNT(sent_m)
   );

   // low byte first, same stimulus and same handshake timing
   acc_tx_scheduler #(.DATA_W(16), .DEPTH_LOG2(2), .MSB_FIRST(1'b0)) dut_lsb (
      .CLK(clk_sys), .RESET(rst_b), .DATA_IN(data_in), .WR(wr),
      .TX_BUSY(tx_busy), .TX_DONE(tx_done), .TX_START(tx_start_l),
      .TX_DATA(tx_data_l), .FULL(full_l), .EMPTY(empty_l),
      .OVERFLOW(ovf_l), .SENT_CNT(sent_l)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Transmitter model: logs each started byte, pulses TX_DONE 10 cycles later.
   initial begin
      tx_done  = 1'b0;
      done_dly = 0;
      forever begin
         @(negedge clk_sys);
         tx_done = 1'b0;
         if (!rst_b) begin
            done_dly = 0;
         end else if (tx_start_m) begin
            bytes_m.push_back(tx_data_m);
            bytes_l.push_back(tx_data_l);
            done_dly = 10;
         end else if (done_dly > 0) begin
            done_dly--;
            if (done_dly == 0) tx_done = 1'b1;
         end
      end
   end

   task automatic wr_word(input logic [15:0] d);
      @(posedge clk_sys); #1;
      data_in = d;
      wr      = 1'b1;
      @(posedge clk_sys); #1;
      wr      = 1'b0;
   endtask

   task automatic wait_sent(input logic [7:0] target, input int budget);
      int n;
      n = 0;
      while (sent_m !== target && n < budget) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= budget) check_val("sent_timeout", {24'h0, sent_m}, {24'h0, target});
   endtask

   task automatic clear_log();
      bytes_m.delete();
      bytes_l.delete();
   endtask

   initial begin
      logic [7:0] exp_b [10];
      logic [7:0] base;
      int         hi_cnt;

      rst_b   = 1'b0;
      data_in = 16'h0000;
      wr      = 1'b0;
      tx_busy = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      check_val("rst_start", {31'h0, tx_start_m}, 32'h0);
      check_val("rst_data",  {24'h0, tx_data_m},  32'h00);
      check_val("rst_full",  {31'h0, full_m},     32'h0);
      check_val("rst_empty", {31'h0, empty_m},    32'h1);
      check_val("rst_ovf",   {31'h0, ovf_m},      32'h0);
      check_val("rst_sent",  {24'h0, sent_m},     32'h0);
      rst_b = 1'b1;

      // single word, both byte orders
      clear_log();
      wr_word(16'hA55A);
      wait_sent(8'd1, 200);
      repeat (30) @(negedge clk_sys);
      check_val("one_starts", bytes_m.size(), 2);
      if (bytes_m.size() == 2) begin
         check_val("msb_b0", {24'h0, bytes_m[0]}, 32'hA5);
         check_val("msb_b1", {24'h0, bytes_m[1]}, 32'h5A);
         check_val("lsb_b0", {24'h0, bytes_l[0]}, 32'h5A);
         check_val("lsb_b1", {24'h0, bytes_l[1]}, 32'hA5);
      end
      check_val("one_sent",  {24'h0, sent_m},  32'h1);
      check_val("one_empty", {31'h0, empty_m}, 32'h1);
      check_val("lsb_sent",  {24'h0, sent_l},  32'h1);

      // transmitter busy while the FSM waits in SEND_A
      clear_log();
      tx_busy = 1'b1;
      wr_word(16'h1234);
      hi_cnt = 0;
      repeat (20) begin
         @(negedge clk_sys);
         if (tx_start_m) hi_cnt++;
      end
      check_val("busy_no_start", hi_cnt, 0);
      @(posedge clk_sys); #1;
      tx_busy = 1'b0;
      @(negedge clk_sys);
      check_val("busy_rel_start", {31'h0, tx_start_m}, 32'h1);
      check_val("busy_rel_byte",  {24'h0, tx_data_m},  32'h12);
      @(negedge clk_sys);
      check_val("busy_rel_pulse", {31'h0, tx_start_m}, 32'h0);
      wait_sent(8'd2, 200);
      repeat (5) @(negedge clk_sys);
      check_val("busy_bytes", bytes_m.size(), 2);

      // fill the FIFO while the word 00FF is held in SEND_A by a busy transmitter
      clear_log();
      base    = sent_m;
      tx_busy = 1'b1;
      wr_word(16'h00FF);
      repeat (4) @(posedge clk_sys);
      #1;
      wr = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         data_in = 16'(i);
         @(posedge clk_sys); #1;
         if (i == 3) check_val("full_after3", {31'h0, full_m}, 32'h0);
         if (i == 4) check_val("full_after4", {31'h0, full_m}, 32'h1);
      end
      wr = 1'b0;
      check_val("ovf_set", {31'h0, ovf_m}, 32'h1);
      tx_busy = 1'b0;
      wait_sent(base + 8'd5, 600);
      repeat (5) @(negedge clk_sys);
      exp_b = '{8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
      check_val("ovf_nbytes", bytes_m.size(), 10);
      if (bytes_m.size() == 10)
         for (int i = 0; i < 10; i++)
            check_val($sformatf("ovf_byte%0d", i), {24'h0, bytes_m[i]}, {24'h0, exp_b[i]});
      check_val("ovf_sticky", {31'h0, ovf_m},   32'h1);
      check_val("ovf_empty",  {31'h0, empty_m}, 32'h1);

      // reset in WAIT_A with three words queued behind the one in flight
      clear_log();
      @(posedge clk_sys); #1;
      wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 16'hC000 + 16'(i);
         @(posedge clk_sys); #1;
      end
      wr = 1'b0;
      begin
         int n;
         n = 0;
         while (bytes_m.size() == 0 && n < 50) begin
            @(negedge clk_sys);
            n++;
         end
         if (n >= 50) check_val("rst_mid_timeout", bytes_m.size(), 1);
      end
      repeat (3) @(posedge clk_sys);
      #1;
      rst_b = 1'b0;
      #1;
      check_val("rstmid_empty", {31'h0, empty_m},    32'h1);
      check_val("rstmid_start", {31'h0, tx_start_m}, 32'h0);
      check_val("rstmid_sent",  {24'h0, sent_m},     32'h0);
      check_val("rstmid_ovf",   {31'h0, ovf_m},      32'h0);
      @(posedge clk_sys); #1;
      rst_b = 1'b1;
      clear_log();
      repeat (60) @(negedge clk_sys);
      check_val("rstmid_quiet", bytes_m.size(), 0);
      check_val("rstmid_sent2", {24'h0, sent_m}, 32'h0);

      // 256 words: counter wraps, nothing dropped
      clear_log();
      for (int i = 0; i < 256; i++) begin
         wr_word(16'(i));
         wait_sent(8'(i + 1), 200);
      end
      repeat (5) @(negedge clk_sys);
      check_val("wrap_sent",   {24'h0, sent_m}, 32'h0);
      check_val("wrap_ovf",    {31'h0, ovf_m},  32'h0);
      check_val("wrap_nbytes", bytes_m.size(),  512);
      if (bytes_m.size() == 512) begin
         check_val("wrap_last_hi", {24'h0, bytes_m[510]}, 32'h00);
         check_val("wrap_last_lo", {24'h0, bytes_m[511]}, 32'hFF);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
